// File: rtl/mas_mod_stream_if.sv
// Operand/result handshake bundle for mas_mod_stream.
// The acc_mode signal exists only when MAS_ACC_EN is defined.
`timescale 1ns/1ps
interface mas_mod_stream_if #(
  parameter int DW = 5
);
  localparam int TW = 2 * DW;

  // Operand side
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] din1;
  logic [DW-1:0] din2;
  logic [1:0]    sel;
  logic [DW-1:0] q;
`ifdef MAS_ACC_EN
  logic          acc_mode;
`endif

  // Result side
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] tdout;
  logic [DW-1:0] dout;
  logic [1:0]    tcmp;

`ifdef MAS_ACC_EN
  modport master (
    output in_valid, din1, din2, sel, q, acc_mode, out_ready,
    input  in_ready, out_valid, tdout, dout, tcmp
  );
  modport slave (
    input  in_valid, din1, din2, sel, q, acc_mode, out_ready,
    output in_ready, out_valid, tdout, dout, tcmp
  );
`else
  modport master (
    output in_valid, din1, din2, sel, q, out_ready,
    input  in_ready, out_valid, tdout, dout, tcmp
  );
  modport slave (
    input  in_valid, din1, din2, sel, q, out_ready,
    output in_ready, out_valid, tdout, dout, tcmp
  );
`endif
endinterface

// File: rtl/mas_mod_stream.sv
// Modular ALU with fixed-latency shift-subtract reduction to the residue in [0,q).
// Optional accumulator feedback is enabled by defining MAS_ACC_EN.
`timescale 1ns/1ps
module mas_mod_stream #(
  parameter int DW = 5
) (
  input logic             clk,
  input logic             rst_n,
  mas_mod_stream_if.slave bus
);
  localparam int TW = 2 * DW;
  localparam int MW = TW + DW;
  localparam int KW = $clog2(TW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_RED,
    S_FIX,
    S_OUT
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] mod_q, mod_d;
  logic [1:0]    sel_q, sel_d;
  logic [MW-1:0] m_q, m_d;
  logic [KW-1:0] k_q, k_d;
  logic [TW-1:0] tdout_q, tdout_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [1:0]    tcmp_q, tcmp_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
`ifdef MAS_ACC_EN
  logic [DW-1:0] acc_q, acc_d;
`endif

  logic signed [TW-1:0] a_ext, b_ext, q_ext, t_calc;
  logic        [TW-1:0] t_abs;
  logic        [MW-1:0] q_shift;
  logic        [DW-1:0] a_src;
  logic                 q_err;

  assign a_ext   = {{DW{a_q[DW-1]}}, a_q};
  assign b_ext   = {{DW{b_q[DW-1]}}, b_q};
  assign q_ext   = {{DW{mod_q[DW-1]}}, mod_q};
  assign q_err   = mod_q[DW-1] || (mod_q == '0);
  // Wide enough that q<<(TW-1) never loses bits.
  assign q_shift = MW'(mod_q) << k_q;

`ifdef MAS_ACC_EN
  assign a_src = bus.acc_mode ? acc_q : bus.din1;
`else
  assign a_src = bus.din1;
`endif

  // Low TW bits of the product of sign-extended operands equal the full signed product.
  always_comb begin
    t_calc = '0;
    case (sel_q)
      2'b00:   t_calc = a_ext + b_ext;
      2'b01:   t_calc = a_ext - b_ext;
      2'b10:   t_calc = a_ext * b_ext;
      default: t_calc = a_ext;
    endcase
    t_abs = t_calc[TW-1] ? TW'(-t_calc) : TW'(t_calc);
  end

  always_comb begin
    // NOTE: every _d takes its held value first, so no path through the case can infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mod_d   = mod_q;
    sel_d   = sel_q;
    m_d     = m_q;
    k_d     = k_q;
    tdout_d = tdout_q;
    dout_d  = dout_q;
    tcmp_d  = tcmp_q;
`ifdef MAS_ACC_EN
    acc_d   = acc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = a_src;
          b_d     = bus.din2;
          sel_d   = bus.sel;
          mod_d   = bus.q;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        tdout_d = t_calc;
        if (q_err)                tcmp_d = 2'b11;
        else if (t_calc >= q_ext) tcmp_d = 2'b01;
        else if (t_calc[TW-1])    tcmp_d = 2'b10;
        else                      tcmp_d = 2'b00;
        m_d     = {{DW{1'b0}}, t_abs};
        k_d     = KW'(TW - 1);
        state_d = S_RED;
      end

      // One conditional subtract of q<<k per cycle; skipped entirely for an illegal modulus.
      S_RED: begin
        if (!q_err && (m_q >= q_shift)) m_d = m_q - q_shift;
        if (k_q == '0) state_d = S_FIX;
        else           k_d     = k_q - 1'b1;
      end

      // A negative T with nonzero |T| mod q folds back into [0,q).
      S_FIX: begin
        if (q_err)                           dout_d = '0;
        else if (tdout_q[TW-1] && m_q != '0) dout_d = mod_q - m_q[DW-1:0];
        else                                 dout_d = m_q[DW-1:0];
        state_d = S_OUT;
      end

      S_OUT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
`ifdef MAS_ACC_EN
          acc_d   = dout_q;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_OUT);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mod_q       <= '0;
      sel_q       <= '0;
      m_q         <= '0;
      k_q         <= '0;
      tdout_q     <= '0;
      dout_q      <= '0;
      tcmp_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef MAS_ACC_EN
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mod_q       <= mod_d;
      sel_q       <= sel_d;
      m_q         <= m_d;
      k_q         <= k_d;
      tdout_q     <= tdout_d;
      dout_q      <= dout_d;
      tcmp_q      <= tcmp_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef MAS_ACC_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.tdout     = tdout_q;
  assign bus.dout      = dout_q;
  assign bus.tcmp      = tcmp_q;
endmodule

// File: tb/tb_mas_mod_stream.sv
// Scoreboard bench for mas_mod_stream: directed vectors, backpressure, mid-op reset,
// then randomized ops against an integer-arithmetic reference (MAS_ACC_EN aware).
`timescale 1ns/1ps
module tb_mas_mod_stream;
  localparam int DW  = 5;
  localparam int TW  = 2 * DW;
  localparam int LAT = TW + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mas_mod_stream_if #(.DW(DW)) bus ();

  mas_mod_stream #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tdout;
    int dout;
    int tcmp;
    int acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   errors    = 0;
  int   checks    = 0;
  int   cyc       = 0;
  int   model_acc = 0;
  int   bp_mode   = 0;  // 0: always ready, 1: random, 2: hold low
`ifdef MAS_ACC_EN
  bit   use_acc   = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic, residue by Euclidean modulo.
  function automatic exp_t model(input int a, input int b, input int sel,
                                 input int qq, input int acc_cyc);
    exp_t r;
    int   t;
    case (sel)
      0:       t = a + b;
      1:       t = a - b;
      2:       t = a * b;
      default: t = a;
    endcase
    r.tdout   = t;
    r.acc_cyc = acc_cyc;
    if (qq <= 0) begin
      r.tcmp = 3;
      r.dout = 0;
    end else begin
      r.tcmp = (t >= qq) ? 1 : ((t < 0) ? 2 : 0);
      r.dout = ((t % qq) + qq) % qq;
    end
    return r;
  endfunction

  task automatic issue(input int a, input int b, input int sel, input int qq);
    int ea;
    int waited;
    waited = 0;
    @(negedge clk);
    bus.din1     = DW'(a);
    bus.din2     = DW'(b);
    bus.sel      = 2'(sel);
    bus.q        = DW'(qq);
    bus.in_valid = 1'b1;
`ifdef MAS_ACC_EN
    bus.acc_mode = use_acc;
`endif
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: in_ready still 0 after %0d cycles", waited);
      bus.in_valid = 1'b0;
      return;
    end
    ea = a;
`ifdef MAS_ACC_EN
    if (use_acc) ea = model_acc;
`endif
    sb.push_back(model(ea, b, sel, qq, cyc + 1));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready), 1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_tdout"},     32'(bus.tdout), 0);
    check({tag, "_dout"},      32'(bus.dout), 0);
    check({tag, "_tcmp"},      32'(bus.tcmp), 0);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every valid cycle must match the head of the scoreboard.
  initial begin
    bit   seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
      end else if (bus.out_valid) begin
        check("in_ready_in_out", 32'(bus.in_ready), 0);
        if (sb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_output: tdout=%0d dout=%0d with empty scoreboard",
                   $signed(bus.tdout), bus.dout);
        end else begin
          e = sb[0];
          if (!seen) check("latency", cyc - e.acc_cyc, LAT);
          check("tdout", 32'($signed(bus.tdout)), e.tdout);
          check("dout",  32'(bus.dout), e.dout);
          check("tcmp",  32'(bus.tcmp), e.tcmp);
        end
        seen = 1'b1;
        if (bus.out_ready) begin
          if (sb.size() > 0) begin
            e = sb.pop_front();
            model_acc = e.dout;
          end
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, s, qq, n;
    bus.in_valid = 1'b0;
    bus.din1     = '0;
    bus.din2     = '0;
    bus.sel      = '0;
    bus.q        = '0;
`ifdef MAS_ACC_EN
    bus.acc_mode = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed vectors
    issue(6, 5, 0, 7);
    issue(2, 6, 1, 7);
    issue(-16, 15, 2, 7);
    issue(3, 1, 0, 0);
    issue(-5, 3, 0, -3);
    issue(-14, 0, 3, 5);
    issue(15, 15, 2, 15);
    bus.in_valid = 1'b0;
    drain();

    // Backpressure: consumer stalls three cycles in OUT
    bp_mode = 2;
    issue(4, 3, 2, 5);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_seen", 32'(bus.out_valid), 1);
    repeat (3) @(negedge clk);
    bp_mode = 0;
    drain();

    // Reset asserted in the middle of RED aborts the op
    issue(-9, 7, 2, 11);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    model_acc = 0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    issue(7, 4, 1, 6);
    bus.in_valid = 1'b0;
    drain();

`ifdef MAS_ACC_EN
    issue(3, 0, 3, 7);
    use_acc = 1'b1;
    issue(0, 6, 0, 7);
    use_acc = 1'b0;
    bus.in_valid = 1'b0;
    drain();
`endif

    // Randomized ops with random backpressure; in_valid stays high between ops
    bp_mode = 1;
    for (int i = 0; i < 150; i++) begin
      a  = int'($urandom_range(0, 31)) - 16;
      b  = int'($urandom_range(0, 31)) - 16;
      s  = int'($urandom_range(0, 3));
      qq = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 16)) - 16
                                       : int'($urandom_range(1, 15));
`ifdef MAS_ACC_EN
      use_acc = ($urandom_range(0, 2) == 0);
`endif
      issue(a, b, s, qq);
    end
    bus.in_valid = 1'b0;
    drain();
    bp_mode = 0;

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
